// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with two combinational read ports
// and one synchronous write port. The write port can load or accumulate.
// Optional features: write->read bypass and a hardwired zero entry.
// A sequential clear engine wipes every entry without needing a reset.
`timescale 1ns/1ps

module reg_file_param #(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 3,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned BYPASS   = 1
) (
  input  logic          CLK,
  input  logic          init_n,
  input  logic          write_en,
  input  logic          wr_mode,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] data_in,
  input  logic [AW-1:0] raddrA,
  input  logic [AW-1:0] raddrB,
  output logic [DW-1:0] data_outA,
  output logic [DW-1:0] data_outB,
  input  logic          clear_req,
  output logic          busy
);

  localparam int unsigned DEPTH    = 2**AW;
  localparam bit          HAS_ZERO = (ZERO_REG != 0);
  localparam bit          HAS_BYP  = (BYPASS != 0);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  logic [DW-1:0] wval;
  logic          wr_active;
  logic          wr_commit;

  assign busy = (state_q == ST_CLEAR);

  // Write value and qualifiers: accumulate adds to the stored entry and wraps.
  always_comb begin
    wval      = wr_mode ? (mem_q[waddr] + data_in) : data_in;
    // A write is only live while the clear engine is idle.
    wr_active = write_en && !busy;
    // The zero entry swallows writes so it can never hold a non-zero value.
    wr_commit = wr_active && !(HAS_ZERO && (waddr == '0));
  end

  // Clear FSM next-state: IDLE waits for a request, CLEAR walks clr_ptr once.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which is what would otherwise infer a latch.
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end
      end
      ST_CLEAR: begin
        // clr_ptr wraps to 0 on its own after the last entry.
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end
        // clear_req is deliberately ignored here; the sweep never restarts.
      end
      default: begin
        state_d   = ST_IDLE;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Storage next-state: a write in IDLE, or one entry zeroed per CLEAR cycle.
  always_comb begin
    mem_d = mem_q;
    if (state_q == ST_CLEAR) begin
      mem_d[clr_ptr_q] = '0;
    end else if (wr_commit) begin
      // A write coinciding with clear_req lands first; the sweep zeroes it later.
      mem_d[waddr] = wval;
    end
  end

  // State and storage registers, all cleared by the asynchronous reset.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      state_q   <= ST_IDLE;
      clr_ptr_q <= '0;
      // NOTE: the storage is built from flops rather than a RAM macro because
      // every entry must read zero straight out of reset, so it is reset here.
      mem_q     <= '{default: '0};
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // sample their _d values from the same edge regardless of statement order.
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      mem_q     <= mem_d;
    end
  end

  // Read ports: zero entry first, then bypass of the live write, then storage.
  always_comb begin
    data_outA = mem_q[raddrA];
    data_outB = mem_q[raddrB];
    if (HAS_ZERO && (raddrA == '0)) begin
      data_outA = '0;
    end else if (HAS_BYP && wr_active && (raddrA == waddr)) begin
      data_outA = wval;
    end
    if (HAS_ZERO && (raddrB == '0)) begin
      data_outB = '0;
    end else if (HAS_BYP && wr_active && (raddrB == waddr)) begin
      data_outB = wval;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed bench for reg_file_param. Three instances share
// one stimulus stream: default (bypass, no zero entry), no-bypass, and zero-entry.
`timescale 1ns/1ps

module tb_reg_file_param;

  logic       CLK;
  logic       init_n;
  logic       write_en;
  logic       wr_mode;
  logic [2:0] waddr;
  logic [7:0] data_in;
  logic [2:0] raddrA;
  logic [2:0] raddrB;
  logic       clear_req;

  logic [7:0] a0, b0, a1, b1, a2, b2;
  logic       busy0, busy1, busy2;

  int checks = 0;
  int errors = 0;

  reg_file_param #(.DW(8), .AW(3), .ZERO_REG(0), .BYPASS(1)) dut (
    .CLK(CLK), .init_n(init_n), .write_en(write_en), .wr_mode(wr_mode),
    .waddr(waddr), .data_in(data_in), .raddrA(raddrA), .raddrB(raddrB),
    .data_outA(a0), .data_outB(b0), .clear_req(clear_req), .busy(busy0)
  );

  reg_file_param #(.DW(8), .AW(3), .ZERO_REG(0), .BYPASS(0)) dut_nb (
    .CLK(CLK), .init_n(init_n), .write_en(write_en), .wr_mode(wr_mode),
    .waddr(waddr), .data_in(data_in), .raddrA(raddrA), .raddrB(raddrB),
    .data_outA(a1), .data_outB(b1), .clear_req(clear_req), .busy(busy1)
  );

  reg_file_param #(.DW(8), .AW(3), .ZERO_REG(1), .BYPASS(1)) dut_z (
    .CLK(CLK), .init_n(init_n), .write_en(write_en), .wr_mode(wr_mode),
    .waddr(waddr), .data_in(data_in), .raddrA(raddrA), .raddrB(raddrB),
    .data_outA(a2), .data_outB(b2), .clear_req(clear_req), .busy(busy2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Single load write on all instances.
  task automatic write_entry(input logic [2:0] addr, input logic [7:0] data);
    write_en = 1'b1; wr_mode = 1'b0; waddr = addr; data_in = data;
    tick();
    write_en = 1'b0;
  endtask

  task automatic test_reset();
    init_n = 1'b0;
    #1;
    checks++;
    if ({busy0, busy1, busy2} !== 3'b000) begin
      errors++; $display("FAIL reset_busy: got %b want 000", {busy0, busy1, busy2});
    end
    @(negedge CLK);
    init_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      raddrA = 3'(i); raddrB = 3'(7 - i);
      #1;
      checks++;
      if ({a0, b0, a1, b1, a2, b2} !== 48'h0) begin
        errors++;
        $display("FAIL reset_read[%0d]: got %h %h %h %h %h %h want all 00", i, a0, b0, a1, b1, a2, b2);
      end
    end
    checks++;
    if (busy0 !== 1'b0) begin
      errors++; $display("FAIL reset_busy_after: got %b want 0", busy0);
    end
  endtask

  task automatic test_accumulate();
    write_en = 1'b1; wr_mode = 1'b0; waddr = 3'd1; data_in = 8'd3;
    tick();
    wr_mode = 1'b1; data_in = 8'd6;
    tick();
    write_en = 1'b0; raddrA = 3'd1; raddrB = 3'd1;
    #1;
    checks++;
    if ({a0, b0, a1, a2} !== {4{8'd9}}) begin
      errors++; $display("FAIL acc_load_add: got %0d %0d %0d %0d want 9", a0, b0, a1, a2);
    end
    // 9 + 250 = 259 wraps to 3
    write_en = 1'b1; wr_mode = 1'b1; data_in = 8'd250;
    #1;
    checks++;
    if (a0 !== 8'd3 || a1 !== 8'd9) begin
      errors++; $display("FAIL acc_wrap_bypass: got byp=%0d nobyp=%0d want 3 9", a0, a1);
    end
    tick();
    write_en = 1'b0; wr_mode = 1'b0;
    #1;
    checks++;
    if ({a0, a1, a2} !== {3{8'd3}}) begin
      errors++; $display("FAIL acc_wrap: got %0d %0d %0d want 3", a0, a1, a2);
    end
  endtask

  task automatic test_bypass();
    write_entry(3'd3, 8'd5);
    write_en = 1'b1; wr_mode = 1'b0; waddr = 3'd3; data_in = 8'd7; raddrB = 3'd3;
    #1;
    checks++;
    if (b0 !== 8'd7 || b2 !== 8'd7) begin
      errors++; $display("FAIL bypass_same_cycle: got %0d %0d want 7", b0, b2);
    end
    checks++;
    if (b1 !== 8'd5) begin
      errors++; $display("FAIL nobypass_old: got %0d want 5", b1);
    end
    tick();
    write_en = 1'b0;
    #1;
    checks++;
    if (b1 !== 8'd7 || b0 !== 8'd7) begin
      errors++; $display("FAIL nobypass_after_edge: got %0d %0d want 7", b1, b0);
    end
    // Bypass of an accumulate shows the sum, not the addend.
    write_en = 1'b1; wr_mode = 1'b1; data_in = 8'd1; raddrA = 3'd3;
    #1;
    checks++;
    if (a0 !== 8'd8 || a1 !== 8'd7) begin
      errors++; $display("FAIL bypass_acc: got byp=%0d nobyp=%0d want 8 7", a0, a1);
    end
    tick();
    write_en = 1'b0; wr_mode = 1'b0;
  endtask

  task automatic test_zero_reg();
    write_en = 1'b1; wr_mode = 1'b0; waddr = 3'd0; data_in = 8'hAA; raddrA = 3'd0;
    #1;
    checks++;
    if (a0 !== 8'hAA || a2 !== 8'h00) begin
      errors++; $display("FAIL zero_bypass: got %h %h want aa 00", a0, a2);
    end
    tick();
    write_en = 1'b0;
    #1;
    checks++;
    if (a0 !== 8'hAA || a1 !== 8'hAA || a2 !== 8'h00) begin
      errors++; $display("FAIL zero_load: got %h %h %h want aa aa 00", a0, a1, a2);
    end
    write_en = 1'b1; wr_mode = 1'b1; data_in = 8'h01;
    tick();
    write_en = 1'b0; wr_mode = 1'b0;
    #1;
    checks++;
    if (a0 !== 8'hAB || a2 !== 8'h00) begin
      errors++; $display("FAIL zero_acc: got %h %h want ab 00", a0, a2);
    end
  endtask

  task automatic test_clear();
    int busy_cnt;
    for (int i = 0; i < 8; i++) write_entry(3'(i), 8'(i + 1));
    // Write and clear request together: the write still commits.
    clear_req = 1'b1; write_en = 1'b1; wr_mode = 1'b0; waddr = 3'd5; data_in = 8'h77;
    tick();
    clear_req = 1'b0; write_en = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!busy0) break;
      busy_cnt++;
      if (k == 0) begin
        raddrA = 3'd5;
        #1;
        checks++;
        if (a0 !== 8'h77) begin
          errors++; $display("FAIL clear_coincident_write: got %h want 77", a0);
        end
      end
      if (k == 2) begin
        raddrA = 3'd2; raddrB = 3'd7;
        #1;
        checks++;
        if (a0 !== 8'd3 || b0 !== 8'd8 || a1 !== 8'd3) begin
          errors++; $display("FAIL clear_midsweep_read: got %0d %0d %0d want 3 8 3", a0, b0, a1);
        end
        write_en = 1'b1; waddr = 3'd2; data_in = 8'h55;
        #1;
        checks++;
        if (a0 !== 8'd3) begin
          errors++; $display("FAIL clear_no_bypass: got %h want 03", a0);
        end
      end
      if (k == 4) clear_req = 1'b1;
      tick();
      write_en = 1'b0; clear_req = 1'b0;
    end
    checks++;
    if (busy_cnt !== 8) begin
      errors++; $display("FAIL clear_busy_cycles: got %0d want 8", busy_cnt);
    end
    tick();
    checks++;
    if ({busy0, busy1, busy2} !== 3'b000) begin
      errors++; $display("FAIL clear_no_restart: got %b want 000", {busy0, busy1, busy2});
    end
    for (int i = 0; i < 8; i++) begin
      raddrA = 3'(i); raddrB = 3'(i);
      #1;
      checks++;
      if ({a0, b0, a1, a2} !== 32'h0) begin
        errors++; $display("FAIL clear_result[%0d]: got %h %h %h %h want 00", i, a0, b0, a1, a2);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int guard;
    for (int i = 0; i < 8; i++) write_entry(3'(i), 8'(8'h10 + i));
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick(); tick(); tick();
    raddrA = 3'd3;
    #1;
    checks++;
    if (a0 !== 8'h13 || busy0 !== 1'b1) begin
      errors++; $display("FAIL midclear_state: got %h busy=%b want 13 1", a0, busy0);
    end
    init_n = 1'b0;
    #1;
    checks++;
    if ({busy0, busy1, busy2} !== 3'b000) begin
      errors++; $display("FAIL midclear_reset_busy: got %b want 000", {busy0, busy1, busy2});
    end
    for (int i = 0; i < 8; i++) begin
      raddrA = 3'(i);
      #1;
      checks++;
      if (a0 !== 8'h00 || a1 !== 8'h00) begin
        errors++; $display("FAIL midclear_reset_read[%0d]: got %h %h want 00", i, a0, a1);
      end
    end
    init_n = 1'b1;
    tick();
    write_entry(3'd0, 8'h31);
    write_entry(3'd1, 8'h32);
    write_entry(3'd7, 8'h37);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    // One CLEAR edge has passed: only entry 0 should be gone.
    raddrA = 3'd0; raddrB = 3'd1;
    #1;
    checks++;
    if (a0 !== 8'h00 || b0 !== 8'h32) begin
      errors++; $display("FAIL restart_ptr0: got %h %h want 00 32", a0, b0);
    end
    guard = 0;
    while (busy0 && guard < 20) begin
      tick();
      guard++;
    end
    checks++;
    if (busy0 !== 1'b0) begin
      errors++; $display("FAIL restart_timeout: busy still %b after %0d cycles", busy0, guard);
    end
    raddrA = 3'd7;
    #1;
    checks++;
    if (a0 !== 8'h00) begin
      errors++; $display("FAIL restart_result: got %h want 00", a0);
    end
  endtask

  initial begin
    init_n = 1'b0; write_en = 1'b0; wr_mode = 1'b0; waddr = '0; data_in = '0;
    raddrA = '0; raddrB = '0; clear_req = 1'b0;
    test_reset();
    test_accumulate();
    test_bypass();
    test_zero_reg();
    test_clear();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
